// File: rtl/game_pkg.sv
// Shared battleship types and constants: board cell encoding, board origins, mark colours.
package game_pkg;

    typedef enum logic [1:0] {
        CELL_EMPTY = 2'b00,
        CELL_SHIP  = 2'b01,
        CELL_MISS  = 2'b10,
        CELL_HIT   = 2'b11
    } cell_state_t;

    localparam int unsigned GRID_N_DEF    = 10;
    localparam int unsigned CELL_LOG2_DEF = 5;

    localparam int unsigned HOST_X_DEF  = 64;
    localparam int unsigned HOST_Y_DEF  = 96;
    localparam int unsigned GUEST_X_DEF = 448;
    localparam int unsigned GUEST_Y_DEF = 96;

    localparam logic [11:0] HIT_RGB_DEF  = 12'hF00;
    localparam logic [11:0] MISS_RGB_DEF = 12'hFFF;
    localparam logic [11:0] SHIP_RGB_DEF = 12'h888;

endpackage

// File: rtl/vga_if.sv
// VGA pixel bus: 11-bit counters, sync/blank strobes and 12-bit rgb (38 bits total).
interface vga_if;
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hsync;
    logic        vsync;
    logic        hblnk;
    logic        vblnk;
    logic [11:0] rgb;

    modport in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
    modport out (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

// File: rtl/delay.sv
// Generic WIDTH-bit shift register delaying a bus by CLK_DEL clocks, cleared by reset.
module delay #(
    parameter int unsigned WIDTH   = 38,
    parameter int unsigned CLK_DEL = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] pipe [CLK_DEL];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(CLK_DEL); i++) begin
                pipe[i] <= '0;
            end
        end else begin
            pipe[0] <= din;
            for (int i = 1; i < int'(CLK_DEL); i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    assign dout = pipe[CLK_DEL-1];

endmodule

// File: rtl/draw_marks.sv
// Overlays hit crosses, miss dots and host ships on both boards; 3-clk latency.
// Optional DRAW_MARKS_BLINK_EN: blink the most recent guest hit with the frame counter.
module draw_marks
    import game_pkg::*;
#(
    parameter int unsigned GRID_N     = GRID_N_DEF,
    parameter int unsigned CELL_LOG2  = CELL_LOG2_DEF,
    parameter int unsigned HOST_X     = HOST_X_DEF,
    parameter int unsigned HOST_Y     = HOST_Y_DEF,
    parameter int unsigned GUEST_X    = GUEST_X_DEF,
    parameter int unsigned GUEST_Y    = GUEST_Y_DEF,
    parameter logic [11:0] HIT_RGB    = HIT_RGB_DEF,
    parameter logic [11:0] MISS_RGB   = MISS_RGB_DEF,
    parameter logic [11:0] SHIP_RGB   = SHIP_RGB_DEF,
    parameter int unsigned BLINK_LOG2 = 5,
    parameter int unsigned ADDR_W     = $clog2(GRID_N * GRID_N)
) (
    input  logic              clk,
    input  logic              rst,
    vga_if.in                 vga_in,
    vga_if.out                vga_out,
    output logic [ADDR_W-1:0] cell_addr,
    output logic              board_sel,
    input  logic [1:0]        cell_state,
    input  logic [ADDR_W-1:0] last_hit_addr,
    input  logic              last_hit_valid
);

    localparam int unsigned S       = 1 << CELL_LOG2;
    localparam int unsigned BOARD_W = GRID_N * S;
    localparam int          DOT_LO  = int'(S / 2 - S / 8);
    localparam int          DOT_HI  = int'(S / 2 + S / 8);

    // Stage 1: board/cell decode
    logic [10:0]          h_dx, h_dy, g_dx, g_dy, dx, dy, col, row, addr_lin;
    logic                 in_host, in_guest, in_d, sel_d;
    logic [ADDR_W-1:0]    addr_d;
    logic [CELL_LOG2-1:0] ox_d, oy_d;

    always_comb begin
        h_dx     = vga_in.hcount - 11'(HOST_X);
        h_dy     = vga_in.vcount - 11'(HOST_Y);
        g_dx     = vga_in.hcount - 11'(GUEST_X);
        g_dy     = vga_in.vcount - 11'(GUEST_Y);
        in_host  = (vga_in.hcount >= 11'(HOST_X)) && (h_dx < 11'(BOARD_W)) &&
                   (vga_in.vcount >= 11'(HOST_Y)) && (h_dy < 11'(BOARD_W));
        in_guest = (vga_in.hcount >= 11'(GUEST_X)) && (g_dx < 11'(BOARD_W)) &&
                   (vga_in.vcount >= 11'(GUEST_Y)) && (g_dy < 11'(BOARD_W));
        in_d     = in_host;
        sel_d    = 1'b0;
        dx       = h_dx;
        dy       = h_dy;
        if (!in_host && in_guest) begin
            in_d  = 1'b1;
            sel_d = 1'b1;
            dx    = g_dx;
            dy    = g_dy;
        end
        col      = dx >> CELL_LOG2;
        row      = dy >> CELL_LOG2;
        addr_lin = row * 11'(GRID_N) + col;
        addr_d   = in_d ? ADDR_W'(addr_lin) : '0;
        ox_d     = in_d ? dx[CELL_LOG2-1:0] : '0;
        oy_d     = in_d ? dy[CELL_LOG2-1:0] : '0;
    end

    logic                 s1_in, s2_in, s2_sel;
    logic [CELL_LOG2-1:0] s1_ox, s1_oy, s2_ox, s2_oy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cell_addr <= '0;
            board_sel <= 1'b0;
            s1_in     <= 1'b0;
            s1_ox     <= '0;
            s1_oy     <= '0;
            s2_in     <= 1'b0;
            s2_sel    <= 1'b0;
            s2_ox     <= '0;
            s2_oy     <= '0;
        end else begin
            cell_addr <= addr_d;
            board_sel <= sel_d;
            s1_in     <= in_d;
            s1_ox     <= ox_d;
            s1_oy     <= oy_d;
            s2_in     <= s1_in;
            s2_sel    <= board_sel;
            s2_ox     <= s1_ox;
            s2_oy     <= s1_oy;
        end
    end

    logic blink_off;

`ifdef DRAW_MARKS_BLINK_EN
    logic [BLINK_LOG2-1:0] frame_cnt;
    logic                  vsync_q, armed_q;
    logic [ADDR_W-1:0]     s2_addr;

    // armed_q keeps a vsync that rose during reset from counting at release
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cnt <= '0;
            vsync_q   <= 1'b0;
            armed_q   <= 1'b0;
            s2_addr   <= '0;
        end else begin
            vsync_q <= vga_in.vsync;
            armed_q <= 1'b1;
            s2_addr <= cell_addr;
            if (armed_q && vga_in.vsync && !vsync_q) begin
                frame_cnt <= frame_cnt + BLINK_LOG2'(1);
            end
        end
    end

    assign blink_off = s2_sel && last_hit_valid && (s2_addr == last_hit_addr) &&
                       frame_cnt[BLINK_LOG2-1];
`else
    logic unused_blink;
    assign unused_blink = ^{last_hit_addr, last_hit_valid};
    assign blink_off    = 1'b0;
`endif

    // Stage 3: mark decision, registered alongside the delayed bus
    cell_state_t st;
    int          diag, anti;
    logic        on_cross, in_dot, mark_en_d, mark_en_q;
    logic [11:0] mark_rgb_d, mark_rgb_q;

    always_comb begin
        st         = cell_state_t'(cell_state);
        diag       = int'(s2_ox) - int'(s2_oy);
        anti       = int'(s2_ox) + int'(s2_oy) - int'(S - 1);
        on_cross   = (diag >= -1 && diag <= 1) || (anti >= -1 && anti <= 1);
        in_dot     = (int'(s2_ox) >= DOT_LO) && (int'(s2_ox) < DOT_HI) &&
                     (int'(s2_oy) >= DOT_LO) && (int'(s2_oy) < DOT_HI);
        mark_en_d  = 1'b0;
        mark_rgb_d = '0;
        if (s2_in) begin
            case (st)
                CELL_HIT: begin
                    if (blink_off) begin
                        mark_en_d = 1'b0;
                    end else if (on_cross) begin
                        mark_en_d  = 1'b1;
                        mark_rgb_d = HIT_RGB;
                    end else if (!s2_sel) begin
                        mark_en_d  = 1'b1;
                        mark_rgb_d = SHIP_RGB;
                    end
                end
                CELL_MISS: begin
                    mark_en_d  = in_dot;
                    mark_rgb_d = MISS_RGB;
                end
                CELL_SHIP: begin
                    mark_en_d  = !s2_sel;
                    mark_rgb_d = SHIP_RGB;
                end
                default: mark_en_d = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mark_en_q  <= 1'b0;
            mark_rgb_q <= '0;
        end else begin
            mark_en_q  <= mark_en_d;
            mark_rgb_q <= mark_rgb_d;
        end
    end

    logic [37:0] bus_in, bus_dly;

    assign bus_in = {vga_in.hcount, vga_in.vcount, vga_in.hsync, vga_in.vsync,
                     vga_in.hblnk, vga_in.vblnk, vga_in.rgb};

    delay #(
        .WIDTH   (38),
        .CLK_DEL (3)
    ) u_delay (
        .clk  (clk),
        .rst  (rst),
        .din  (bus_in),
        .dout (bus_dly)
    );

    assign vga_out.hcount = bus_dly[37:27];
    assign vga_out.vcount = bus_dly[26:16];
    assign vga_out.hsync  = bus_dly[15];
    assign vga_out.vsync  = bus_dly[14];
    assign vga_out.hblnk  = bus_dly[13];
    assign vga_out.vblnk  = bus_dly[12];
    assign vga_out.rgb    = mark_en_q ? mark_rgb_q : bus_dly[11:0];

endmodule

// File: tb/tb_draw_marks.sv
// Self-checking bench for draw_marks with a 1-cycle synchronous board RAM model.
module tb_draw_marks;
    import game_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] cell_addr;
    logic       board_sel;
    logic [1:0] cell_state = 2'b00;
    logic [6:0] last_hit_addr = 7'd23;
    logic       last_hit_valid = 1'b1;

    always #5 clk = ~clk;

    vga_if vin ();
    vga_if vout ();

    draw_marks dut (
        .clk            (clk),
        .rst            (rst),
        .vga_in         (vin),
        .vga_out        (vout),
        .cell_addr      (cell_addr),
        .board_sel      (board_sel),
        .cell_state     (cell_state),
        .last_hit_addr  (last_hit_addr),
        .last_hit_valid (last_hit_valid)
    );

    logic [1:0] host_mem  [100];
    logic [1:0] guest_mem [100];

    always @(posedge clk) begin
        cell_state <= board_sel ? guest_mem[cell_addr] : host_mem[cell_addr];
    end

    logic [37:0] out_word;
    assign out_word = {vout.hcount, vout.vcount, vout.hsync, vout.vsync,
                       vout.hblnk, vout.vblnk, vout.rgb};

    int          asserts = 0;
    int          fails = 0;
    logic [37:0] exp_q [$];
    logic [37:0] got_q [$];
    logic [2:0]  vpipe = 3'b000;

    // One pixel per clock; sync/blank bits follow coordinate bits so timing is checked too.
    task automatic step(input logic [10:0] h, input logic [10:0] v, input logic vs,
                        input logic [11:0] rgb, input logic chk, input logic [11:0] exp_rgb);
        vin.hcount = h;
        vin.vcount = v;
        vin.hsync  = h[0];
        vin.vsync  = vs;
        vin.hblnk  = v[0];
        vin.vblnk  = h[1];
        vin.rgb    = rgb;
        if (chk) exp_q.push_back({h, v, h[0], vs, v[0], h[1], exp_rgb});
        @(posedge clk);
        #1;
        vpipe = {vpipe[1:0], chk};
        if (vpipe[2]) got_q.push_back(out_word);
    endtask

    task automatic flush();
        for (int i = 0; i < 3; i++) step(11'd0, 11'd0, 1'b0, 12'h000, 1'b0, 12'h000);
    endtask

    task automatic test_reset();
        logic [37:0] want;
        vin.hcount = 11'd5; vin.vcount = 11'd7; vin.hsync = 1'b1; vin.vsync = 1'b0;
        vin.hblnk = 1'b1; vin.vblnk = 1'b0; vin.rgb = 12'hABC;
        want = {11'd5, 11'd7, 1'b1, 1'b0, 1'b1, 1'b0, 12'hABC};
        @(negedge clk);
        rst = 1'b0;
        for (int e = 1; e <= 3; e++) begin
            @(posedge clk);
            #1;
            asserts++;
            if (out_word !== ((e == 3) ? want : 38'd0)) begin
                fails++;
                $display("FAIL reset_release_edge%0d: got %h required %h", e, out_word,
                         (e == 3) ? want : 38'd0);
            end
        end
        // Mid-line asynchronous reset with active board pixels flowing
        for (int i = 0; i < 4; i++) step(11'(544 + i), 11'd170, 1'b0, 12'h123, 1'b0, 12'h000);
        #2 rst = 1'b1;
        #1;
        asserts++;
        if (out_word !== 38'd0) begin
            fails++;
            $display("FAIL reset_async_vga_out: got %h required 0", out_word);
        end
        asserts++;
        if (cell_addr !== 7'd0) begin
            fails++;
            $display("FAIL reset_async_cell_addr: got %0d required 0", cell_addr);
        end
        asserts++;
        if (board_sel !== 1'b0) begin
            fails++;
            $display("FAIL reset_async_board_sel: got %b required 0", board_sel);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        vpipe = 3'b000;
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic test_addressing();
        logic [37:0] e, g;
        step(11'd165, 11'd167, 1'b0, 12'h321, 1'b1, 12'h888);
        asserts++;
        if (cell_addr !== 7'd23 || board_sel !== 1'b0) begin
            fails++;
            $display("FAIL addr_host23: got %0d/%b required 23/0", cell_addr, board_sel);
        end
        step(11'd767, 11'd415, 1'b0, 12'h321, 1'b1, 12'h321);
        asserts++;
        if (cell_addr !== 7'd99 || board_sel !== 1'b1) begin
            fails++;
            $display("FAIL addr_guest99: got %0d/%b required 99/1", cell_addr, board_sel);
        end
        step(11'd768, 11'd415, 1'b0, 12'h321, 1'b1, 12'h321);
        asserts++;
        if (cell_addr !== 7'd0 || board_sel !== 1'b0) begin
            fails++;
            $display("FAIL addr_outside: got %0d/%b required 0/0", cell_addr, board_sel);
        end
        // Last host pixel is inside (ship drawn), next pixel is outside
        step(11'd383, 11'd415, 1'b0, 12'h555, 1'b1, 12'h888);
        step(11'd384, 11'd415, 1'b0, 12'h555, 1'b1, 12'h555);
        step(11'd63, 11'd100, 1'b0, 12'h555, 1'b1, 12'h555);
        flush();
        for (int idx = 0; exp_q.size() > 0; idx++) begin
            e = exp_q.pop_front();
            asserts++;
            if (got_q.size() == 0) begin
                fails++;
                $display("FAIL addressing_rgb[%0d]: got nothing required %h", idx, e);
            end else begin
                g = got_q.pop_front();
                if (g !== e) begin
                    fails++;
                    $display("FAIL addressing_rgb[%0d]: got %h required %h", idx, g, e);
                end
            end
        end
        got_q.delete();
    endtask

    task automatic test_hit_cross();
        logic [37:0] e, g;
        step(11'd554, 11'd170, 1'b0, 12'h123, 1'b1, 12'hF00);  // guest (10,10) diagonal
        step(11'd554, 11'd180, 1'b0, 12'h123, 1'b1, 12'hF00);  // (10,20): 10+20 = S-1-1
        step(11'd554, 11'd185, 1'b0, 12'h123, 1'b1, 12'h123);  // (10,25) off both arms
        step(11'd170, 11'd170, 1'b0, 12'h123, 1'b1, 12'hF00);  // host (10,10)
        step(11'd170, 11'd185, 1'b0, 12'h123, 1'b1, 12'h888);  // host (10,25)
        step(11'd191, 11'd160, 1'b0, 12'h123, 1'b1, 12'hF00);  // host (31,0) corner
        step(11'd176, 11'd180, 1'b0, 12'h123, 1'b1, 12'h888);  // host (16,20)
        flush();
        for (int idx = 0; exp_q.size() > 0; idx++) begin
            e = exp_q.pop_front();
            asserts++;
            if (got_q.size() == 0) begin
                fails++;
                $display("FAIL hit_cross[%0d]: got nothing required %h", idx, e);
            end else begin
                g = got_q.pop_front();
                if (g !== e) begin
                    fails++;
                    $display("FAIL hit_cross[%0d]: got %h required %h", idx, g, e);
                end
            end
        end
        got_q.delete();
    endtask

    task automatic test_miss_dot();
        logic [37:0] e, g;
        step(11'd240, 11'd240, 1'b0, 12'h0F0, 1'b1, 12'hFFF);  // (16,16)
        step(11'd235, 11'd240, 1'b0, 12'h0F0, 1'b1, 12'h0F0);  // (11,16)
        step(11'd243, 11'd243, 1'b0, 12'h0F0, 1'b1, 12'hFFF);  // (19,19)
        step(11'd244, 11'd240, 1'b0, 12'h0F0, 1'b1, 12'h0F0);  // (20,16)
        step(11'd236, 11'd236, 1'b0, 12'h0F0, 1'b1, 12'hFFF);  // (12,12)
        step(11'd240, 11'd235, 1'b0, 12'h0F0, 1'b1, 12'h0F0);  // (16,11)
        flush();
        for (int idx = 0; exp_q.size() > 0; idx++) begin
            e = exp_q.pop_front();
            asserts++;
            if (got_q.size() == 0) begin
                fails++;
                $display("FAIL miss_dot[%0d]: got nothing required %h", idx, e);
            end else begin
                g = got_q.pop_front();
                if (g !== e) begin
                    fails++;
                    $display("FAIL miss_dot[%0d]: got %h required %h", idx, g, e);
                end
            end
        end
        got_q.delete();
    endtask

    task automatic test_hidden_ships();
        logic [37:0] e, g;
        step(11'd453, 11'd101, 1'b0, 12'h08F, 1'b1, 12'h08F);  // guest ship hidden
        step(11'd355, 11'd387, 1'b0, 12'h08F, 1'b1, 12'h888);  // host ship shown
        step(11'd485, 11'd101, 1'b0, 12'h08F, 1'b1, 12'h08F);  // guest empty
        step(11'd101, 11'd101, 1'b0, 12'h08F, 1'b1, 12'h08F);  // host empty
        flush();
        for (int idx = 0; exp_q.size() > 0; idx++) begin
            e = exp_q.pop_front();
            asserts++;
            if (got_q.size() == 0) begin
                fails++;
                $display("FAIL hidden_ships[%0d]: got nothing required %h", idx, e);
            end else begin
                g = got_q.pop_front();
                if (g !== e) begin
                    fails++;
                    $display("FAIL hidden_ships[%0d]: got %h required %h", idx, g, e);
                end
            end
        end
        got_q.delete();
    endtask

    task automatic pulse_vsync(input int n);
        for (int i = 0; i < n; i++) begin
            step(11'd0, 11'd0, 1'b1, 12'h000, 1'b0, 12'h000);
            step(11'd0, 11'd0, 1'b0, 12'h000, 1'b0, 12'h000);
        end
    endtask

    task automatic blink_probe(input int frame);
        logic hidden;
`ifdef DRAW_MARKS_BLINK_EN
        hidden = (frame % 32) >= 16;
`else
        hidden = 1'b0;
`endif
        step(11'd554, 11'd170, 1'b0, 12'h0A0, 1'b1, hidden ? 12'h0A0 : 12'hF00);
        step(11'd170, 11'd170, 1'b0, 12'h0A0, 1'b1, 12'hF00);  // host hit never blinks
        step(11'd586, 11'd170, 1'b0, 12'h0A0, 1'b1, 12'hF00);  // guest cell 24 hit
    endtask

    task automatic test_blink();
        logic [37:0] e, g;
        rst = 1'b1;
        #3;
        @(negedge clk);
        rst = 1'b0;
        vpipe = 3'b000;
        exp_q.delete();
        got_q.delete();
        flush();
        blink_probe(0);
        pulse_vsync(15);
        blink_probe(15);
        pulse_vsync(1);
        blink_probe(16);
        pulse_vsync(15);
        blink_probe(31);
        pulse_vsync(1);
        blink_probe(32);
        flush();
        for (int idx = 0; exp_q.size() > 0; idx++) begin
            e = exp_q.pop_front();
            asserts++;
            if (got_q.size() == 0) begin
                fails++;
                $display("FAIL blink[%0d]: got nothing required %h", idx, e);
            end else begin
                g = got_q.pop_front();
                if (g !== e) begin
                    fails++;
                    $display("FAIL blink[%0d]: got %h required %h", idx, g, e);
                end
            end
        end
        got_q.delete();
    endtask

    initial begin
        for (int i = 0; i < 100; i++) begin
            host_mem[i]  = CELL_EMPTY;
            guest_mem[i] = CELL_EMPTY;
        end
        host_mem[23]  = CELL_HIT;
        host_mem[45]  = CELL_MISS;
        host_mem[99]  = CELL_SHIP;
        guest_mem[0]  = CELL_SHIP;
        guest_mem[23] = CELL_HIT;
        guest_mem[24] = CELL_HIT;
        vin.hcount = '0; vin.vcount = '0; vin.hsync = 1'b0; vin.vsync = 1'b0;
        vin.hblnk = 1'b0; vin.vblnk = 1'b0; vin.rgb = '0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_addressing();
        test_hit_cross();
        test_miss_dot();
        test_hidden_ships();
        test_blink();
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

endmodule
